// File: rtl/rv32i_dmem_if.sv
// Load/store bus between the RV32I ALU stage (initiator) and the data memory.
interface rv32i_dmem_if;
  logic [31:0] addr;
  logic        load;
  logic        store;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        stall;
  logic        access_err;

  modport master (
    output addr, load, store, st_be, st_data,
    input  ld_data, stall, access_err
  );

  modport slave (
    input  addr, load, store, st_be, st_data,
    output ld_data, stall, access_err
  );
endinterface

// File: rtl/rv32i_dmem.sv
// Data-memory responder: byte-enabled single-cycle stores, word loads with a
// programmable number of read wait states, and out-of-window/conflict flagging.
module rv32i_dmem #(
  parameter int unsigned ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  rv32i_dmem_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam int unsigned WAIT_M1  = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
  localparam logic [3:0]  CNT_INIT = WAIT_M1[3:0];
  localparam bit          HAS_WAIT = (RD_WAIT != 0);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Word-organised RAM, one byte per lane so stores can be lane-masked.
  logic [3:0][7:0] ram [DEPTH];
  logic [3:0][7:0] rd_word_q;

  logic                 in_win;
  logic [ADDR_BITS-1:0] widx;
  logic                 store_act;
  logic                 store_we;
  logic                 read_fire;
  logic                 conflict;
  logic                 stall_c;
  logic                 err_d;

  // A read and a store in the same cycle always share the bus address, so the
  // lanes written that cycle are kept and merged over the RAM output.
  logic                 rd_valid_q;
  logic                 oob_q;
  logic [3:0]           byp_be_q;
  logic [31:0]          byp_data_q;
  logic [31:0]          hold_q;
  logic [31:0]          rd_merged;
  logic                 err_q;

  logic                 unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign in_win    = (bus.addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign widx      = bus.addr[ADDR_BITS+1:2];
  assign store_act = bus.store && (bus.st_be != 4'b0000);
  assign store_we  = reset_n && store_act && in_win;

  // Load FSM next state, read strobe, stall and conflict detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    read_fire = 1'b0;
    stall_c   = 1'b0;
    conflict  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load && bus.store) begin
          conflict = 1'b1;
        end else if (bus.load) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
            stall_c = 1'b1;
          end else begin
            read_fire = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          stall_c = 1'b1;
        end else begin
          read_fire = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = (store_act && !in_win) || conflict || (read_fire && !in_win);

  // RAM byte-lane writes and registered word read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_we && bus.st_be[i]) begin
        ram[widx][i] <= bus.st_data[i*8 +: 8];
      end
    end
    if (read_fire) begin
      rd_word_q <= ram[widx];
    end
  end

  // FSM state, read bookkeeping, held load data and the error pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
      byp_be_q   <= 4'b0000;
      byp_data_q <= 32'h0;
      hold_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= read_fire;
      err_q      <= err_d;
      if (read_fire) begin
        oob_q      <= !in_win;
        byp_be_q   <= store_we ? bus.st_be : 4'b0000;
        byp_data_q <= bus.st_data;
      end
      if (rd_valid_q) begin
        hold_q <= rd_merged;
      end
    end
  end

  // Per-lane merge of same-cycle store data over the RAM read word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_merged[gi*8 +: 8] = oob_q ? 8'h00 :
                                  (byp_be_q[gi] ? byp_data_q[gi*8 +: 8] : rd_word_q[gi]);
  end

  assign bus.ld_data    = rd_valid_q ? rd_merged : hold_q;
  assign bus.stall      = reset_n && stall_c;
  assign bus.access_err = err_q;

endmodule

// File: tb/tb_rv32i_dmem.sv
// Directed bench for rv32i_dmem: five instances with different read wait
// counts share one stimulus bus, gated by a select.
module tb_rv32i_dmem;
  localparam logic [2:0] D0 = 3'd0, D2 = 3'd1, D3 = 3'd2, D4 = 3'd3, D15 = 3'd4;
  localparam logic [4:0][3:0] WAITS = {4'd15, 4'd4, 4'd3, 4'd2, 4'd0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sel = D0;
  logic        load_v = 1'b0;
  logic        store_v = 1'b0;
  logic [31:0] addr_v = 32'h0;
  logic [3:0]  be_v = 4'h0;
  logic [31:0] data_v = 32'h0;

  logic [4:0][31:0] ld_a;
  logic [4:0]       stall_a;
  logic [4:0]       err_a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    rv32i_dmem_if bus_i ();
    assign bus_i.addr    = addr_v;
    assign bus_i.load    = load_v && (sel == 3'(gi));
    assign bus_i.store   = store_v && (sel == 3'(gi));
    assign bus_i.st_be   = be_v;
    assign bus_i.st_data = data_v;
    assign ld_a[gi]      = bus_i.ld_data;
    assign stall_a[gi]   = bus_i.stall;
    assign err_a[gi]     = bus_i.access_err;

    rv32i_dmem #(
      .ADDR_BITS(12),
      .BASE_ADDR(32'h0000_0000),
      .RD_WAIT(int'(WAITS[gi]))
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus_i.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs change 1 time unit after the edge, outputs looked at 1 unit later.
  task automatic drive(input logic [2:0] s, input logic l, input logic st,
                       input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(posedge clk);
    #1;
    sel = s; load_v = l; store_v = st; addr_v = a; be_v = be; data_v = d;
    #1;
    $display("cyc t=%0t sel=%0d load=%b store=%b addr=%h be=%h data=%h | ld=%h stall=%b err=%b",
             $time, s, l, st, a, be, d, ld_a[sel], stall_a[sel], err_a[sel]);
  endtask

  // Load held while stalled; checks every stall cycle, the falling cycle and the data.
  task automatic load_seq(input logic [2:0] s, input logic [31:0] a, input int w,
                          input logic [31:0] exp);
    for (int i = 0; i <= w; i++) begin
      drive(s, 1'b1, 1'b0, a, 4'h0, 32'h0);
      chk($sformatf("stall_w%0d_c%0d", w, i), {31'b0, stall_a[s]}, (i < w) ? 32'd1 : 32'd0);
    end
    drive(s, 1'b0, 1'b0, a, 4'h0, 32'h0);
    chk($sformatf("ld_w%0d_%h", w, a), ld_a[s], exp);
    chk($sformatf("stall_after_w%0d", w), {31'b0, stall_a[s]}, 32'd0);
  endtask

  initial begin
    // Reset behaviour
    drive(D4, 1'b1, 1'b0, 32'h60, 4'h0, 32'h0);
    chk("rst_stall", {31'b0, stall_a[D4]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("rst_ld", ld_a[D0], 32'h0);
    chk("rst_err", {31'b0, err_a[D0]}, 32'd0);
    reset_n = 1'b1;

    // RD_WAIT=0 store then load
    drive(D0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk("w0_st_stall", {31'b0, stall_a[D0]}, 32'd0);
    drive(D0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("w0_ld_stall", {31'b0, stall_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("w0_ld_data", ld_a[D0], 32'hDEADBEEF);
    chk("w0_err", {31'b0, err_a[D0]}, 32'd0);

    // Byte lanes
    drive(D0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0);
    drive(D0, 1'b0, 1'b1, 32'h20, 4'b0100, 32'h00AB0000);
    drive(D0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("lane2", ld_a[D0], 32'h00AB0000);
    drive(D0, 1'b0, 1'b1, 32'h20, 4'b0001, 32'h000000CD);
    drive(D0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("lane0", ld_a[D0], 32'h00AB00CD);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("ld_hold", ld_a[D0], 32'h00AB00CD);
    drive(D0, 1'b0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    drive(D0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    chk("be0_err", {31'b0, err_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("be0_data", ld_a[D0], 32'h00AB00CD);

    // Out of window
    drive(D0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5);
    drive(D0, 1'b0, 1'b1, 32'h4000, 4'hF, 32'h12345678);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oob_st_err", {31'b0, err_a[D0]}, 32'd1);
    drive(D0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oob_st_err_once", {31'b0, err_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oob_ram_kept", ld_a[D0], 32'hA5A5A5A5);
    drive(D0, 1'b1, 1'b0, 32'h4000, 4'h0, 32'h0);
    chk("oob_ld_err_early", {31'b0, err_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oob_ld_data", ld_a[D0], 32'h0);
    chk("oob_ld_err", {31'b0, err_a[D0]}, 32'd1);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("oob_ld_err_once", {31'b0, err_a[D0]}, 32'd0);

    // Simultaneous load and store
    drive(D0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h0BADF00D);
    chk("cfl_stall", {31'b0, stall_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("cfl_err", {31'b0, err_a[D0]}, 32'd1);
    chk("cfl_no_read", ld_a[D0], 32'h0);
    drive(D0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
    chk("cfl_err_once", {31'b0, err_a[D0]}, 32'd0);
    drive(D0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("cfl_store_won", ld_a[D0], 32'h0BADF00D);

    // RD_WAIT=3 and RD_WAIT=15
    drive(D3, 1'b0, 1'b1, 32'h30, 4'hF, 32'hCAFE0003);
    load_seq(D3, 32'h30, 3, 32'hCAFE0003);
    drive(D15, 1'b0, 1'b1, 32'h40, 4'hF, 32'h0F0F0F0F);
    load_seq(D15, 32'h40, 15, 32'h0F0F0F0F);

    // RD_WAIT=2, store into the pending word during WAIT
    drive(D2, 1'b0, 1'b1, 32'h50, 4'hF, 32'h55555555);
    drive(D2, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
    drive(D2, 1'b1, 1'b1, 32'h50, 4'hF, 32'h11223344);
    chk("sw_a_stall", {31'b0, stall_a[D2]}, 32'd1);
    drive(D2, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
    chk("sw_a_stall_low", {31'b0, stall_a[D2]}, 32'd0);
    drive(D2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("sw_a_data", ld_a[D2], 32'h11223344);
    chk("sw_a_err", {31'b0, err_a[D2]}, 32'd0);
    drive(D2, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
    drive(D2, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
    drive(D2, 1'b1, 1'b1, 32'h50, 4'b0011, 32'h0000AAAA);
    chk("sw_b_stall", {31'b0, stall_a[D2]}, 32'd0);
    drive(D2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("sw_b_data", ld_a[D2], 32'h1122AAAA);
    chk("sw_b_err", {31'b0, err_a[D2]}, 32'd0);
    load_seq(D2, 32'h50, 2, 32'h1122AAAA);

    // Reset in the second WAIT cycle with RD_WAIT=4
    drive(D4, 1'b0, 1'b1, 32'h60, 4'hF, 32'h77778888);
    load_seq(D4, 32'h60, 4, 32'h77778888);
    drive(D4, 1'b0, 1'b1, 32'h64, 4'hF, 32'h99990000);
    drive(D4, 1'b1, 1'b0, 32'h64, 4'h0, 32'h0);
    drive(D4, 1'b1, 1'b0, 32'h64, 4'h0, 32'h0);
    drive(D4, 1'b1, 1'b0, 32'h64, 4'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rstw_stall_now", {31'b0, stall_a[D4]}, 32'd0);
    chk("rstw_ld_before", ld_a[D4], 32'h77778888);
    drive(D4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("rstw_ld_zero", ld_a[D4], 32'h0);
    chk("rstw_stall", {31'b0, stall_a[D4]}, 32'd0);
    chk("rstw_err", {31'b0, err_a[D4]}, 32'd0);
    reset_n = 1'b1;
    load_seq(D4, 32'h60, 4, 32'h77778888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32i_dmem.md
# rv32i_dmem

Data-memory responder for the RV32I soft processor: the target end of the ALU stage's load/store interface. It accepts single-cycle byte-enabled stores and word loads on a word-aligned address, holds a synchronous word-organised RAM, and inserts a programmable number of read wait states, signalled back to the pipeline on `stall`. Accesses outside its window are flagged on `access_err`.

## Interface
- `ADDR_BITS`, 12, word-address width; RAM depth is 2^ADDR_BITS words.
- `BASE_ADDR`, 32'h0000_0000, byte base address of the window; must be aligned to 4·2^ADDR_BITS.
- `RD_WAIT`, 0, read wait states, 0..15.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `addr`  in  32  byte address; `addr[1:0]` ignored.
- `load`  in  1  load request.
- `store`  in  1  store request.
- `st_be`  in  4  store byte enables; bit i writes byte lane i.
- `st_data`  in  32  store data, already lane-aligned by the initiator.
- `ld_data`  out  32  registered load data, full word.
- `stall`  out  1  load not yet complete; initiator holds `load` and `addr`.
- `access_err`  out  1  one-cycle pulse on an out-of-window or conflicting access.

## Operation
- In window: `addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]`. Word index is `addr[ADDR_BITS+1:2]`.
- Store: when `store`=1, the bytes selected by `st_be` are written at the end of that cycle. There is no wait state and `stall` is never asserted for a store. `st_be`=0 writes nothing and raises no error.
- Load FSM states:
  - IDLE:
    - `load` with `RD_WAIT`=0: read at the end of the cycle; remain in IDLE.
    - `load` with `RD_WAIT`>0: `cnt` <= RD_WAIT-1; go to WAIT.
  - WAIT:
    - `cnt`!=0: `cnt` decrements.
    - `cnt`==0: read at the end of the cycle; go to IDLE.
- `stall` is combinational: (IDLE & `load` & RD_WAIT!=0) | (WAIT & `cnt`!=0).
- `ld_data` holds its value until the next read completes. An out-of-window read returns 32'h0 with the same wait timing.
- Out-of-window store: dropped.
- `access_err`: registered pulse in the cycle after the offending access is accepted. Causes:
  - out-of-window load (raised at read completion) or store;
  - `load`&`store` asserted together in IDLE. The store wins, the load is ignored, and no wait sequence starts.
- Store during WAIT: accepted and written. If it targets the same word as the pending read, the read returns the post-write data, because the read occurs later.
- Initiator rule: the cycle after `stall` falls, `load` is either deasserted or carries a new access. A `load` seen in IDLE always starts a new access.

## Timing
- Reset values: `ld_data`=0, `access_err`=0, state IDLE, `cnt`=0. `stall`=0 while `reset_n`=0. RAM contents are not cleared.
- Load issued in cycle N (accepted in IDLE):
  - `stall` is high in cycles N..N+RD_WAIT-1;
  - the read occurs at the end of cycle N+RD_WAIT;
  - `ld_data` is valid from cycle N+RD_WAIT+1.
- Store in cycle N: the data is readable by a load issued in cycle N+1.
- Reset during WAIT: return to IDLE and drop `stall` immediately. The pending read is abandoned and `ld_data` becomes 0.
- `cnt` is 4 bits. RD_WAIT=15 gives 15 stall cycles; the counter never wraps.

## Test plan
- RD_WAIT=0: store 32'hDEADBEEF with be=4'hF to 0x10 in cycle 0; load 0x10 in cycle 1 -> `ld_data`=32'hDEADBEEF in cycle 2, `stall` never high.
- Byte lanes: word 0x20=0; store be=4'b0100 with `st_data`=32'h00AB0000 -> load returns 32'h00AB0000. Then store be=4'b0001 with 32'h000000CD -> load returns 32'h00AB00CD.
- RD_WAIT=3: load issued in cycle 10 -> `stall` high for cycles 10–12 and low in cycle 13; `ld_data` valid in cycle 14. Repeat with RD_WAIT=15 and check 15 stall cycles.
- RD_WAIT=2 with store 32'h11223344 to the same word during WAIT -> load returns 32'h11223344.
- Out of window (BASE_ADDR=0, ADDR_BITS=12): store to 0x4000 -> RAM unchanged and `access_err` pulses once. Load 0x4000 -> `ld_data`=0 and `access_err` pulses in the cycle `ld_data` updates. Simultaneous `load`&`store` -> store written, no stall, `access_err` pulses once.
- Reset: assert `reset_n`=0 in the second WAIT cycle with RD_WAIT=4 -> next cycle `stall`=0, `ld_data`=0, state IDLE. Earlier RAM contents are still readable after reset.
